// File: rtl/uart_pkg.sv
// Shared UART definitions: baud_rate encoding, RX oversampling divisor table
// and the receiver state type. The TX side uses the same baud_rate encoding.
package uart_pkg;

    localparam logic [1:0] BAUD24  = 2'b00;
    localparam logic [1:0] BAUD48  = 2'b01;
    localparam logic [1:0] BAUD96  = 2'b10;
    localparam logic [1:0] BAUD192 = 2'b11;

    localparam int DIV_W = 16;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic int round_div(input int num, input int den);
        return (num + den / 2) / den;
    endfunction

    // Clocks per oversample tick, rounded to nearest. At 25 MHz x16 this
    // gives 651 / 326 / 163 / 81. Every arm folds to a constant.
    function automatic logic [DIV_W-1:0] div_for(input logic [1:0] baud_rate,
                                                 input int clk_hz,
                                                 input int oversample);
        logic [DIV_W-1:0] div;
        case (baud_rate)
            BAUD24:  div = DIV_W'(round_div(clk_hz, oversample * 2400));
            BAUD48:  div = DIV_W'(round_div(clk_hz, oversample * 4800));
            BAUD96:  div = DIV_W'(round_div(clk_hz, oversample * 9600));
            default: div = DIV_W'(round_div(clk_hz, oversample * 19200));
        endcase
        return div;
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversampling tick generator for the receiver; restart realigns the tick
// phase to a detected start edge.
module uart_rx_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 25_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] baud_rate,
    input  logic       restart,
    output logic       tick
);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] div;

    assign div = div_for(baud_rate, CLK_HZ, OVERSAMPLE);

    // >= rather than == so a switch to a smaller divisor still wraps.
    assign tick = (count >= (div - DIV_W'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (restart || tick) begin
            count <= '0;
        end else begin
            count <= count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: rx synchroniser, start-bit qualification, mid-bit sampling
// and 8N1/8E1/8O1 reassembly with per-byte parity and framing flags.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int CLK_HZ     = 25_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           baud_rate,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    logic rx_m, rx_s, rx_d;
    logic fall, tick, restart, deliver;

    rx_state_t             state, state_n;
    logic [TW-1:0]         tcnt, tcnt_n;
    logic [BW-1:0]         bcnt, bcnt_n;
    logic [DATA_BITS-1:0]  shift, shift_n;
    logic                  mismatch, mismatch_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    // Only a 1-to-0 transition starts a frame, so a held break cannot retrigger.
    assign fall    = rx_d & ~rx_s;
    assign rx_busy = (state != RX_IDLE);

    uart_rx_tick_gen #(
        .CLK_HZ     (CLK_HZ),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick_gen (
        .clk       (clk),
        .reset     (reset),
        .baud_rate (baud_rate),
        .restart   (restart),
        .tick      (tick)
    );

    always_comb begin
        state_n    = state;
        tcnt_n     = tcnt;
        bcnt_n     = bcnt;
        shift_n    = shift;
        mismatch_n = mismatch;
        restart    = 1'b0;
        deliver    = 1'b0;
        case (state)
            RX_IDLE: begin
                if (fall) begin
                    state_n = RX_START;
                    tcnt_n  = '0;
                    restart = 1'b1;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (tcnt == TW'(OVERSAMPLE / 2 - 1)) begin
                        tcnt_n     = '0;
                        bcnt_n     = '0;
                        mismatch_n = 1'b0;
                        state_n    = rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        tcnt_n = tcnt + TW'(1);
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    tcnt_n = tcnt + TW'(1);
                    if (tcnt == TW'(OVERSAMPLE - 1)) begin
                        shift_n = {rx_s, shift[DATA_BITS-1:1]};
                        bcnt_n  = bcnt + BW'(1);
                        if (bcnt == BW'(DATA_BITS - 1)) begin
                            state_n = parity_en ? RX_PARITY : RX_STOP;
                        end
                    end
                end
            end
            RX_PARITY: begin
                if (tick) begin
                    tcnt_n = tcnt + TW'(1);
                    if (tcnt == TW'(OVERSAMPLE - 1)) begin
                        mismatch_n = (rx_s != ((^shift) ^ parity_odd));
                        state_n    = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                // Leaving at mid stop bit keeps a back-to-back start edge visible.
                if (tick && (tcnt == TW'(OVERSAMPLE - 1))) begin
                    deliver = 1'b1;
                    state_n = RX_IDLE;
                end else if (tick) begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RX_IDLE;
            tcnt     <= '0;
            bcnt     <= '0;
            shift    <= '0;
            mismatch <= 1'b0;
        end else begin
            state    <= state_n;
            tcnt     <= tcnt_n;
            bcnt     <= bcnt_n;
            shift    <= shift_n;
            mismatch <= mismatch_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= deliver;
            if (deliver) begin
                rx_data    <= shift;
                frame_err  <= ~rx_s;
                parity_err <= parity_en & mismatch;
            end
        end
    end

endmodule
